// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller: opcodes, FSM states
// and the {WB,ME,EX} control bundle handed to the datapath ID stage.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [1:0] wb;  // {RegWrite, ALU-select}
    logic [2:0] me;  // {Branch, MemRead, MemWrite}
    logic [3:0] ex;  // {RegDst, ALUOp[1:0], ALUSrc}
  } ctrl_t;

endpackage

// File: rtl/pipe_control_main_decoder.sv
// Combinational opcode -> {WB,ME,EX} main control decoder; unknown opcodes and
// HALT produce an all-zero bundle.
module main_decoder
  import pipe_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: ctrl = '{wb: 2'b11, me: 3'b000, ex: 4'b0100};
      OP_LW:    ctrl = '{wb: 2'b10, me: 3'b010, ex: 4'b1001};
      OP_SW:    ctrl = '{wb: 2'b00, me: 3'b001, ex: 4'b1001};
      OP_BEQ:   ctrl = '{wb: 2'b00, me: 3'b100, ex: 4'b0010};
      OP_ADDI:  ctrl = '{wb: 2'b11, me: 3'b000, ex: 4'b1001};
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// Pipeline sequencing controller: owns pc and IF/ID, emits ID-stage controls,
// inserts load-use bubbles, redirects on taken branches and drains on HALT.
module pipe_control
  import pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET     = 32'h0,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_if,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [1:0]  WBID,
  output logic [2:0]  MEID,
  output logic [3:0]  EXID,
  output logic        flush,
  output logic        stall,
  output logic        halted,
  output pipe_state_e state
);

  localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [CW-1:0] drain_cnt;
  logic          mr_ex;
  logic [4:0]    rt_ex;
  ctrl_t         dec_ctrl;
  ctrl_t         emit_ctrl;
  logic [5:0]    opcode;
  logic          uses_rt;
  logic          redirect;
  logic          hazard;

  assign opcode = instr[31:26];

  main_decoder u_main_decoder (
    .opcode (opcode),
    .ctrl   (dec_ctrl)
  );

  assign uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  // A branch seen after the pipe has fully halted is ignored; only reset leaves HALTED.
  assign redirect = branch_taken && (state != HALTED);
  assign hazard   = mr_ex && (rt_ex != 5'd0) &&
                    ((rt_ex == instr[25:21]) || ((rt_ex == instr[20:16]) && uses_rt));
  assign stall    = (state == RUN) && hazard && !redirect;
  assign flush    = redirect;
  assign halted   = (state == HALTED);

  // instr=0 is the bubble/NOP encoding and must not raise RegWrite.
  always_comb begin
    emit_ctrl = '0;
    if ((state == RUN) && !stall && !redirect && (instr != 32'h0))
      emit_ctrl = dec_ctrl;
  end

  assign WBID = emit_ctrl.wb;
  assign MEID = emit_ctrl.me;
  assign EXID = emit_ctrl.ex;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= PC_RESET;
      instr     <= 32'h0;
      mr_ex     <= 1'b0;
      rt_ex     <= 5'd0;
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      mr_ex <= emit_ctrl.me[1];
      rt_ex <= instr[20:16];
      if (redirect) begin
        pc        <= branch_target;
        instr     <= 32'h0;
        state     <= RUN;
        drain_cnt <= '0;
      end else begin
        case (state)
          RUN: begin
            if (!stall) begin
              if (opcode == OP_HALT) begin
                state     <= DRAIN;
                drain_cnt <= CW'(DRAIN_CYCLES);
              end else begin
                pc    <= pc + 32'd4;
                instr <= instr_if;
              end
            end
          end
          DRAIN: begin
            drain_cnt <= drain_cnt - CW'(1);
            if (drain_cnt <= CW'(1))
              state <= HALTED;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: decoder table, issue, load-use bubble,
// branch flush, HALT drain, wrong-path HALT recovery and asynchronous resets.
module tb_pipe_control;
  import pipe_pkg::*;

  localparam int W = 78;

  localparam logic [31:0] I_ADD  = 32'h00221820;  // add $3,$1,$2
  localparam logic [31:0] I_LW1  = 32'h8C010000;  // lw  $1,0($0)
  localparam logic [31:0] I_LW0  = 32'h8C000000;  // lw  $0,0($0)
  localparam logic [31:0] I_ADD0 = 32'h00001820;  // add $3,$0,$0
  localparam logic [31:0] I_ADDI = 32'h20010005;  // addi $1,$0,5
  localparam logic [31:0] I_SW   = 32'hAC220004;  // sw  $2,4($1)
  localparam logic [31:0] I_BEQ  = 32'h10220003;  // beq $1,$2,3
  localparam logic [31:0] I_HALT = 32'hFC000000;

  localparam logic [8:0] C0     = 9'b00_000_0000;
  localparam logic [8:0] C_R    = 9'b11_000_0100;
  localparam logic [8:0] C_LW   = 9'b10_010_1001;
  localparam logic [8:0] C_SW   = 9'b00_001_1001;
  localparam logic [8:0] C_BEQ  = 9'b00_100_0010;
  localparam logic [8:0] C_ADDI = 9'b11_000_1001;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] instr_if;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [1:0]  WBID;
  logic [2:0]  MEID;
  logic [3:0]  EXID;
  logic        flush;
  logic        stall;
  logic        halted;
  pipe_state_e state;

  pipe_control #(.PC_RESET(32'h0), .DRAIN_CYCLES(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_if      (instr_if),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .instr         (instr),
    .WBID          (WBID),
    .MEID          (MEID),
    .EXID          (EXID),
    .flush         (flush),
    .stall         (stall),
    .halted        (halted),
    .state         (state)
  );

  logic [5:0] dec_op;
  ctrl_t      dec_ctrl;
  main_decoder u_ref_dec (.opcode(dec_op), .ctrl(dec_ctrl));

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [5:0]   tbl_op [7];
  logic [8:0]   tbl_c  [7];

  function automatic logic [W-1:0] observe();
    return {pc, instr, WBID, MEID, EXID, flush, stall, halted, state};
  endfunction

  task automatic expect_now(input string tag, input logic [31:0] p, input logic [31:0] i,
                            input logic [8:0] c, input logic f, input logic s,
                            input logic h, input pipe_state_e st);
    logic [W-1:0] got;
    logic [W-1:0] want;
    exp_q.push_back({p, i, c, f, s, h, st});
    #1;
    got  = observe();
    want = exp_q.pop_front();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // driver: apply this cycle's inputs, check the cycle, then clock it
  task automatic step(input logic [31:0] ii, input logic bt, input logic [31:0] tgt,
                      input string tag, input logic [31:0] p, input logic [31:0] i,
                      input logic [8:0] c, input logic f, input logic s,
                      input logic h, input pipe_state_e st);
    instr_if      = ii;
    branch_taken  = bt;
    branch_target = tgt;
    #1;
    expect_now(tag, p, i, c, f, s, h, st);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    instr_if = 32'h0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    dec_op = 6'h0;

    tbl_op = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_HALT, 6'b000001};
    tbl_c  = '{C_R, C_LW, C_SW, C_BEQ, C_ADDI, C0, C0};
    for (int k = 0; k < 7; k++) begin
      dec_op = tbl_op[k];
      #1;
      total++;
      assert (dec_ctrl === tbl_c[k]) else begin
        bad++;
        $error("FAIL decode op=%b got=%b exp=%b", tbl_op[k], dec_ctrl, tbl_c[k]);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    expect_now("reset", 32'h0, 32'h0, C0, 0, 0, 0, RUN);
    rst = 1'b1;

    step(I_ADD,  0, 0, "first",        32'h00, 32'h0,  C0,     0, 0, 0, RUN);
    step(I_LW1,  0, 0, "add_issue",    32'h04, I_ADD,  C_R,    0, 0, 0, RUN);
    step(I_ADD,  0, 0, "lw1_issue",    32'h08, I_LW1,  C_LW,   0, 0, 0, RUN);
    step(I_ADDI, 0, 0, "load_use",     32'h0C, I_ADD,  C0,     0, 1, 0, RUN);
    step(I_ADDI, 0, 0, "add_after",    32'h0C, I_ADD,  C_R,    0, 0, 0, RUN);
    step(I_LW0,  0, 0, "addi",         32'h10, I_ADDI, C_ADDI, 0, 0, 0, RUN);
    step(I_ADD0, 0, 0, "lw0",          32'h14, I_LW0,  C_LW,   0, 0, 0, RUN);
    step(I_LW1,  0, 0, "no_stall_rt0", 32'h18, I_ADD0, C_R,    0, 0, 0, RUN);
    step(I_ADD,  0, 0, "lw1_again",    32'h1C, I_LW1,  C_LW,   0, 0, 0, RUN);
    step(I_ADDI, 1, 32'h40, "flush",   32'h20, I_ADD,  C0,     1, 0, 0, RUN);
    step(I_SW,   0, 0, "after_flush",  32'h40, 32'h0,  C0,     0, 0, 0, RUN);
    step(I_BEQ,  0, 0, "sw",           32'h44, I_SW,   C_SW,   0, 0, 0, RUN);
    step(I_HALT, 0, 0, "beq",          32'h48, I_BEQ,  C_BEQ,  0, 0, 0, RUN);
    step(32'h0,  0, 0, "halt_seen",    32'h4C, I_HALT, C0,     0, 0, 0, RUN);
    for (int k = 0; k < 3; k++)
      step(32'h0, 0, 0, "drain",       32'h4C, I_HALT, C0,     0, 0, 0, DRAIN);
    for (int k = 0; k < 10; k++)
      step(32'h0, 0, 0, "halted",      32'h4C, I_HALT, C0,     0, 0, 1, HALTED);

    rst = 1'b0;
    expect_now("rst_halted", 32'h0, 32'h0, C0, 0, 0, 0, RUN);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // HALT on the wrong path: a branch in the second drain cycle resumes RUN
    step(I_HALT, 0, 0, "r2_first",     32'h00, 32'h0,  C0,     0, 0, 0, RUN);
    step(32'h0,  0, 0, "r2_halt",      32'h04, I_HALT, C0,     0, 0, 0, RUN);
    step(32'h0,  0, 0, "r2_drain1",    32'h04, I_HALT, C0,     0, 0, 0, DRAIN);
    step(32'h0,  1, 32'h80, "r2_br",   32'h04, I_HALT, C0,     1, 0, 0, DRAIN);
    step(I_LW1,  0, 0, "r2_redirect",  32'h80, 32'h0,  C0,     0, 0, 0, RUN);
    step(I_ADD,  0, 0, "r2_lw",        32'h84, I_LW1,  C_LW,   0, 0, 0, RUN);
    instr_if = I_ADDI;
    expect_now("r2_stall",             32'h88, I_ADD,  C0,     0, 1, 0, RUN);
    rst = 1'b0;
    expect_now("rst_mid_stall",        32'h0,  32'h0,  C0,     0, 0, 0, RUN);
    @(posedge clk);
    #1;
    rst = 1'b1;

    step(I_HALT, 0, 0, "r3_first",     32'h00, 32'h0,  C0,     0, 0, 0, RUN);
    step(32'h0,  0, 0, "r3_halt",      32'h04, I_HALT, C0,     0, 0, 0, RUN);
    expect_now("r3_drain",             32'h04, I_HALT, C0,     0, 0, 0, DRAIN);
    rst = 1'b0;
    expect_now("rst_mid_drain",        32'h0,  32'h0,  C0,     0, 0, 0, RUN);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(I_ADD,  0, 0, "r3_restart",   32'h00, 32'h0,  C0,     0, 0, 0, RUN);
    step(32'h0,  0, 0, "r3_add",       32'h04, I_ADD,  C_R,    0, 0, 0, RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
